// File: rtl/msrv32_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | msrv32_pkg                                                       |
// | Shared constants and types for the msrv32 multiply/divide unit.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package msrv32_pkg;

  localparam int XLEN        = 32;
  localparam int MULDIV_ITER = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MULDIV_IDLE = 2'b00,
    MULDIV_CALC = 2'b01,
    MULDIV_DONE = 2'b10
  } muldiv_state_e;

endpackage
`default_nettype wire

// File: rtl/msrv32_muldiv_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | msrv32_muldiv_unit_if                                            |
// | Request/result bundle between the pipeline and the M-unit.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface msrv32_muldiv_unit_if;

  logic                           start_in;
  logic [2:0]                     funct3_in;
  logic [msrv32_pkg::XLEN-1:0]    rs_1_in;
  logic [msrv32_pkg::XLEN-1:0]    rs_2_in;
  logic [4:0]                     rd_addr_in;
  logic                           flush_in;
  logic                           busy_out;
  logic                           done_out;
  logic [msrv32_pkg::XLEN-1:0]    result_out;
  logic [4:0]                     rd_addr_out;

  modport master (
    output start_in, funct3_in, rs_1_in, rs_2_in, rd_addr_in, flush_in,
    input  busy_out, done_out, result_out, rd_addr_out
  );

  modport slave (
    input  start_in, funct3_in, rs_1_in, rs_2_in, rd_addr_in, flush_in,
    output busy_out, done_out, result_out, rd_addr_out
  );

endinterface
`default_nettype wire

// File: rtl/msrv32_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | msrv32_muldiv_unit                                               |
// | Iterative RV32M unit: radix-2 shift-add multiply and restoring   |
// | divide on operand magnitudes, sign fixed up on the last step.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module msrv32_muldiv_unit
  import msrv32_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset_in,
  msrv32_muldiv_unit_if.slave   muldiv
);

  muldiv_state_e         r_state;
  muldiv_state_e         w_state_next;

  logic [2:0]            r_funct3;
  logic                  r_sign1;
  logic                  r_sign2;
  logic [XLEN-1:0]       r_operand;
  logic [2*XLEN-1:0]     r_acc;
  logic [4:0]            r_count;
  logic                  r_busy;
  logic                  r_done;
  logic [XLEN-1:0]       r_result;
  logic [4:0]            r_rd_addr;

  logic                  w_start;
  logic                  w_in_div;
  logic                  w_in_signed1;
  logic                  w_in_signed2;
  logic                  w_in_neg1;
  logic                  w_in_neg2;
  logic [XLEN-1:0]       w_in_mag1;
  logic [XLEN-1:0]       w_in_mag2;
  logic                  w_div_zero;
  logic                  w_div_ovf;
  logic                  w_fast;
  logic [XLEN-1:0]       w_fast_result;

  logic [XLEN:0]         w_mul_sum;
  logic [2*XLEN-1:0]     w_mul_next;
  logic [XLEN:0]         w_rem_shift;
  logic [XLEN:0]         w_rem_diff;
  logic [2*XLEN-1:0]     w_div_next;
  logic [2*XLEN-1:0]     w_acc_next;
  logic                  w_last;

  logic                  w_neg_res;
  logic [2*XLEN-1:0]     w_product;
  logic [XLEN-1:0]       w_quot;
  logic [XLEN-1:0]       w_rem;
  logic [XLEN-1:0]       w_final;

  // ---------------- request decode ----------------
  assign w_start      = (r_state == MULDIV_IDLE) && muldiv.start_in && !muldiv.flush_in;
  assign w_in_div     = muldiv.funct3_in[2];
  assign w_in_signed1 = (muldiv.funct3_in == FUNCT3_MULH) || (muldiv.funct3_in == FUNCT3_MULHSU) ||
                        (muldiv.funct3_in == FUNCT3_DIV)  || (muldiv.funct3_in == FUNCT3_REM);
  assign w_in_signed2 = (muldiv.funct3_in == FUNCT3_MULH) || (muldiv.funct3_in == FUNCT3_DIV) ||
                        (muldiv.funct3_in == FUNCT3_REM);
  assign w_in_neg1    = w_in_signed1 && muldiv.rs_1_in[XLEN-1];
  assign w_in_neg2    = w_in_signed2 && muldiv.rs_2_in[XLEN-1];
  assign w_in_mag1    = w_in_neg1 ? (-muldiv.rs_1_in) : muldiv.rs_1_in;
  assign w_in_mag2    = w_in_neg2 ? (-muldiv.rs_2_in) : muldiv.rs_2_in;

  assign w_div_zero   = w_in_div && (muldiv.rs_2_in == '0);
  assign w_div_ovf    = ((muldiv.funct3_in == FUNCT3_DIV) || (muldiv.funct3_in == FUNCT3_REM)) &&
                        (muldiv.rs_1_in == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (muldiv.rs_2_in == '1);
  assign w_fast       = w_div_zero || w_div_ovf;

  // funct3[1] separates remainder from quotient among the divides
  always_comb begin
    w_fast_result = '0;
    if (w_div_zero) begin
      w_fast_result = muldiv.funct3_in[1] ? muldiv.rs_1_in : '1;
    end else begin
      w_fast_result = muldiv.funct3_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // ---------------- iteration datapath ----------------
  // Multiply: r_acc = {partial product high, multiplier shifting out}.
  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_operand} : '0);
  assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
  assign w_rem_shift = r_acc[2*XLEN-2:XLEN-1];
  assign w_rem_diff  = w_rem_shift - {1'b0, r_operand};
  assign w_div_next  = w_rem_diff[XLEN] ?
                       {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                       {w_rem_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  assign w_acc_next  = r_funct3[2] ? w_div_next : w_mul_next;
  assign w_last      = (r_count == 5'(MULDIV_ITER - 1));

  // ---------------- sign correction and result select ----------------
  assign w_neg_res   = r_sign1 ^ r_sign2;
  assign w_product   = w_neg_res ? (-w_acc_next) : w_acc_next;
  assign w_quot      = w_neg_res ? (-w_acc_next[XLEN-1:0]) : w_acc_next[XLEN-1:0];
  assign w_rem       = r_sign1 ? (-w_acc_next[2*XLEN-1:XLEN]) : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_funct3)
      FUNCT3_MUL:                             w_final = w_product[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: w_final = w_product[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                w_final = w_quot;
      default:                                w_final = w_rem;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= MULDIV_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (muldiv.flush_in) begin
      w_state_next = MULDIV_IDLE;
    end else begin
      case (r_state)
        MULDIV_IDLE: begin
          if (muldiv.start_in) begin
            w_state_next = w_fast ? MULDIV_DONE : MULDIV_CALC;
          end
        end
        MULDIV_CALC: begin
          if (w_last) begin
            w_state_next = MULDIV_DONE;
          end
        end
        MULDIV_DONE: w_state_next = MULDIV_IDLE;
        default:     w_state_next = MULDIV_IDLE;
      endcase
    end
  end

  // ---------------- registered datapath and outputs ----------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_funct3  <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_operand <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_rd_addr <= '0;
    end else begin
      r_busy <= (w_state_next != MULDIV_IDLE);
      r_done <= (w_state_next == MULDIV_DONE);
      if (w_start) begin
        r_funct3  <= muldiv.funct3_in;
        r_rd_addr <= muldiv.rd_addr_in;
        r_sign1   <= w_in_neg1;
        r_sign2   <= w_in_neg2;
        r_count   <= '0;
        // The operand that stays put is the addend (mul) or the divisor (div).
        r_operand <= w_in_div ? w_in_mag2 : w_in_mag1;
        r_acc     <= w_in_div ? {{XLEN{1'b0}}, w_in_mag1} : {{XLEN{1'b0}}, w_in_mag2};
        if (w_fast) begin
          r_result <= w_fast_result;
        end
      end else if ((r_state == MULDIV_CALC) && !muldiv.flush_in) begin
        r_acc   <= w_acc_next;
        r_count <= 5'(r_count + 5'd1);
        if (w_last) begin
          r_result <= w_final;
        end
      end
    end
  end

  assign muldiv.busy_out    = r_busy;
  assign muldiv.done_out    = r_done;
  assign muldiv.result_out  = r_result;
  assign muldiv.rd_addr_out = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_msrv32_muldiv_unit                                            |
// | Directed vectors against an arithmetic reference model.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_msrv32_muldiv_unit;
  import msrv32_pkg::*;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;

  msrv32_muldiv_unit_if muldiv_if();

  msrv32_muldiv_unit dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .muldiv   (muldiv_if.slave)
  );

  always #5 clk_in = ~clk_in;

  int          cyc        = 0;
  int          n_checks   = 0;
  int          n_pass     = 0;
  bit          chk_en     = 1'b0;
  int          op_start   = -1;
  int          op_due     = 0;
  int          op_abort   = 32'h7fffffff;
  logic [31:0] op_res     = '0;
  logic [31:0] op_lit     = '0;
  bit          op_has_lit = 1'b0;
  logic [4:0]  op_rd      = '0;

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      FUNCT3_MUL:    begin p = sa * sb; return p[31:0];  end
      FUNCT3_MULH:   begin p = sa * sb; return p[63:32]; end
      FUNCT3_MULHSU: begin p = sa * ub; return p[63:32]; end
      FUNCT3_MULHU:  begin p = ua * ub; return p[63:32]; end
      FUNCT3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      FUNCT3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      FUNCT3_REM:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default:       return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && (b == 0)) ||
           (((f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk_in);
      cyc++;
    end
  end

  initial begin : compare
    logic [31:0] c_last;
    bit          rst_prev;
    bit          exp_act;
    bit          exp_done;
    c_last   = '0;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_prev) c_last = '0;
      rst_prev = reset_in;
      if (chk_en) begin
        exp_act  = (op_start >= 0) && (cyc >= op_start) && (cyc <= op_due) && (cyc < op_abort);
        exp_done = exp_act && (cyc == op_due);
        if (exp_done) c_last = op_res;
        check("done_out",    32'(muldiv_if.done_out),    32'(exp_done));
        check("busy_out",    32'(muldiv_if.busy_out),    32'(exp_act));
        check("result_out",  muldiv_if.result_out,        c_last);
        check("rd_addr_out", 32'(muldiv_if.rd_addr_out), 32'(op_rd));
        if (exp_done && op_has_lit) begin
          check("literal",   muldiv_if.result_out, op_lit);
          check("model_pin", op_res,               op_lit);
        end
      end
    end
  end

  task automatic begin_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] lit, input bit has_lit);
    muldiv_if.start_in   = 1'b1;
    muldiv_if.funct3_in  = f3;
    muldiv_if.rs_1_in    = a;
    muldiv_if.rs_2_in    = b;
    muldiv_if.rd_addr_in = rd;
    @(posedge clk_in); #1;
    op_start   = cyc;
    op_due     = cyc + (is_fast(f3, a, b) ? 0 : MULDIV_ITER);
    op_abort   = 32'h7fffffff;
    op_res     = model(f3, a, b);
    op_rd      = rd;
    op_lit     = lit;
    op_has_lit = has_lit;
    muldiv_if.start_in = 1'b0;
  endtask

  task automatic finish_op();
    while (cyc <= op_due) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit, input bit has_lit);
    begin_op(f3, a, b, rd, lit, has_lit);
    finish_op();
  endtask

  initial begin : driver
    muldiv_if.start_in   = 1'b0;
    muldiv_if.funct3_in  = '0;
    muldiv_if.rs_1_in    = '0;
    muldiv_if.rs_2_in    = '0;
    muldiv_if.rd_addr_in = '0;
    muldiv_if.flush_in   = 1'b0;
    reset_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 chk_en = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    @(posedge clk_in); #1;

    // Multiply
    run_op(FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1);
    run_op(FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 1'b1);
    run_op(FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b1);
    run_op(FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b1);
    run_op(FUNCT3_MULH,   32'hFFFF_FFFE,  32'h0000_0003, 5'd0,  32'hFFFF_FFFF, 1'b1);
    run_op(FUNCT3_MUL,    32'h1234_5678,  32'h9ABC_DEF0, 5'd31, 32'h0,         1'b0);

    // Divide
    run_op(FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, 1'b1);
    run_op(FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, 1'b1);
    run_op(FUNCT3_DIVU,   32'd100,        32'd7,         5'd8,  32'd14,        1'b1);
    run_op(FUNCT3_REMU,   32'd100,        32'd7,         5'd9,  32'd2,         1'b1);
    run_op(FUNCT3_DIV,    32'd100,        32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFDF, 1'b1);
    run_op(FUNCT3_REM,    32'd100,        32'hFFFF_FFFD, 5'd11, 32'd1,         1'b1);
    run_op(FUNCT3_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd12, 32'hFFFF_FFFF, 1'b1);

    // Fast path, issued back to back
    run_op(FUNCT3_DIVU,   32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1);
    run_op(FUNCT3_REM,    32'hFFFF_FFFB,  32'd0,         5'd14, 32'hFFFF_FFFB, 1'b1);
    run_op(FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1);
    run_op(FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0,         1'b1);

    // Flush on the 10th CALC cycle, then an immediate restart
    begin_op(FUNCT3_DIVU, 32'd1000, 32'd3, 5'd17, 32'h0, 1'b0);
    repeat (9) begin @(posedge clk_in); #1; end
    muldiv_if.flush_in = 1'b1;
    @(posedge clk_in); #1;
    muldiv_if.flush_in = 1'b0;
    op_abort = cyc;
    run_op(FUNCT3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd18, 32'h0B00_EA4E, 1'b1);

    // Start pulsed while busy must not disturb the running op
    begin_op(FUNCT3_MUL, 32'd3, 32'd4, 5'd19, 32'd12, 1'b1);
    repeat (5) begin @(posedge clk_in); #1; end
    muldiv_if.start_in   = 1'b1;
    muldiv_if.funct3_in  = FUNCT3_DIV;
    muldiv_if.rs_1_in    = 32'd99;
    muldiv_if.rs_2_in    = 32'd0;
    muldiv_if.rd_addr_in = 5'd20;
    @(posedge clk_in); #1;
    muldiv_if.start_in = 1'b0;
    finish_op();

    // Reset in the middle of CALC
    begin_op(FUNCT3_DIV, 32'd100, 32'd3, 5'd21, 32'h0, 1'b0);
    repeat (7) begin @(posedge clk_in); #1; end
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    op_start = -1;
    op_rd    = '0;
    repeat (2) begin @(posedge clk_in); #1; end
    run_op(FUNCT3_REMU, 32'd1000, 32'd7, 5'd22, 32'd6, 1'b1);

    repeat (3) begin @(posedge clk_in); #1; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
